bf_uart_machine: RTL and testbench



---
 rtl/bf_uart_machine_if.sv | 19 +
 rtl/bf_uart_machine.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_bf_uart_machine.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_uart_machine_if.sv
// Board-facing pins of the Brainfuck UART machine.
// Buttons and UART RX in, UART TX and LEDs out.
interface bf_uart_machine_if;
    logic [3:0] BTN;
    logic       UART_IN;
    logic       UART_OUT;
    logic [2:0] LED0;
    logic [2:0] LED1;

    modport master (
        output BTN, UART_IN,
        input  UART_OUT, LED0, LED1
    );

    modport slave (
        input  BTN, UART_IN,
        output UART_OUT, LED0, LED1
    );
endinterface

// File: rtl/bf_uart_machine.sv
// Brainfuck machine: loads a program over UART RX, runs it on a byte tape,
// emits '.' output on UART TX. LEDs show state and sticky errors.
module bf_uart_machine #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PROG_DEPTH   = 1024,
    parameter int TAPE_DEPTH   = 1024
) (
    input logic              CLK,
    bf_uart_machine_if.slave bus
);
    localparam int PAW = $clog2(PROG_DEPTH);
    localparam int TAW = $clog2(TAPE_DEPTH);
    localparam int CW  = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CW-1:0]  C_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PAW:0]   P_FULL = (PAW+1)'(PROG_DEPTH);
    localparam logic [TAW-1:0] T_LAST = TAW'(TAPE_DEPTH - 1);

    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [3:0] S_LOAD   = 4'd0;
    localparam logic [3:0] S_CLEAR  = 4'd1;
    localparam logic [3:0] S_FETCH  = 4'd2;
    localparam logic [3:0] S_DECODE = 4'd3;
    localparam logic [3:0] S_OUT    = 4'd4;
    localparam logic [3:0] S_IN     = 4'd5;
    localparam logic [3:0] S_FRD    = 4'd6;
    localparam logic [3:0] S_FCHK   = 4'd7;
    localparam logic [3:0] S_BRD    = 4'd8;
    localparam logic [3:0] S_BCHK   = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    logic w_rst;
    logic w_unused;
    assign w_rst    = bus.BTN[0];
    assign w_unused = &{1'b0, bus.BTN[3:2]};

    // ---------------- UART RX ----------------
    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    logic [1:0]    r_rx_st;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bits;
    logic [7:0]    r_rx_sh;
    logic          r_rx_valid;
    logic          r_rx_ferr;

    // Synchronise RX, detect start edge, sample mid-bit, check stop bit
    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_st    <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_sh    <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1    <= bus.UART_IN;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_st)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_st  <= RX_START;
                        r_rx_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == C_HALF) begin
                        r_rx_cnt  <= '0;
                        r_rx_bits <= '0;
                        r_rx_st   <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == C_FULL) begin
                        r_rx_cnt  <= '0;
                        r_rx_sh   <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_bits <= r_rx_bits + 1'b1;
                        if (r_rx_bits == 3'd7) r_rx_st <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == C_FULL) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= RX_IDLE;
                        if (r_rx_s2) r_rx_valid <= 1'b1;
                        else         r_rx_ferr  <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- UART TX ----------------
    logic          r_tx_out;
    logic          r_tx_busy;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_idx;
    logic [8:0]    r_tx_sh;
    logic          w_tx_start;
    logic [7:0]    w_tx_data;

    // Shift out start, 8 data bits LSB first, stop; busy until stop ends
    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_tx_out  <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_idx  <= '0;
            r_tx_sh   <= '0;
        end else if (!r_tx_busy) begin
            if (w_tx_start) begin
                r_tx_busy <= 1'b1;
                r_tx_out  <= 1'b0;
                r_tx_sh   <= {1'b1, w_tx_data};
                r_tx_cnt  <= '0;
                r_tx_idx  <= '0;
            end
        end else if (r_tx_cnt == C_FULL) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 4'd9) begin
                r_tx_busy <= 1'b0;
            end else begin
                r_tx_out <= r_tx_sh[0];
                r_tx_sh  <= {1'b0, r_tx_sh[8:1]};
                r_tx_idx <= r_tx_idx + 1'b1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    // ---------------- Machine ----------------
    logic [7:0]     r_prog [PROG_DEPTH];
    logic [7:0]     r_tape [TAPE_DEPTH];
    logic [7:0]     r_prog_q;
    logic [7:0]     r_tape_q;
    logic [3:0]     r_state;
    logic [PAW-1:0] r_load_addr;
    logic [PAW:0]   r_prog_len;
    logic [PAW:0]   r_pc;
    logic [PAW:0]   r_depth;
    logic [TAW-1:0] r_ptr;
    logic [TAW-1:0] r_clr;
    logic [2:0]     r_err;
    logic [2:0]     r_led0;
    logic [2:0]     r_led1;

    logic           w_pwe;
    logic           w_twe;
    logic [TAW-1:0] w_taddr;
    logic [7:0]     w_tdata;

    assign w_tx_start = (r_state == S_OUT) && !r_tx_busy;
    assign w_tx_data  = r_tape_q;

    // Tape write port: clearing, '+'/'-' update, ',' input
    always_comb begin
        w_pwe   = (r_state == S_LOAD) && r_rx_valid
                  && (r_prog_len != P_FULL);
        w_twe   = 1'b0;
        w_taddr = r_ptr;
        w_tdata = r_tape_q;
        case (r_state)
            S_CLEAR: begin
                w_twe   = 1'b1;
                w_taddr = r_clr;
                w_tdata = 8'd0;
            end
            S_DECODE: begin
                if (r_prog_q == OP_INC) begin
                    w_twe   = 1'b1;
                    w_tdata = r_tape_q + 8'd1;
                end else if (r_prog_q == OP_DEC) begin
                    w_twe   = 1'b1;
                    w_tdata = r_tape_q - 8'd1;
                end
            end
            S_IN: begin
                w_twe   = r_rx_valid;
                w_tdata = r_rx_sh;
            end
            default: ;
        endcase
    end

    // Synchronous-read program and tape RAMs
    always_ff @(posedge CLK) begin
        if (w_pwe) r_prog[r_load_addr] <= r_rx_sh;
        if (w_twe) r_tape[w_taddr] <= w_tdata;
        r_prog_q <= r_prog[r_pc[PAW-1:0]];
        r_tape_q <= r_tape[r_ptr];
    end

    // Load / clear / fetch-execute / bracket-scan state machine
    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_state     <= S_LOAD;
            r_load_addr <= '0;
            r_prog_len  <= '0;
            r_pc        <= '0;
            r_depth     <= '0;
            r_ptr       <= '0;
            r_clr       <= '0;
            r_err       <= '0;
        end else begin
            if (r_rx_ferr) r_err[0] <= 1'b1;
            case (r_state)
                S_LOAD: begin
                    if (r_rx_valid) begin
                        if (r_prog_len == P_FULL) begin
                            r_err[2] <= 1'b1;
                        end else begin
                            r_load_addr <= r_load_addr + 1'b1;
                            r_prog_len  <= r_prog_len + 1'b1;
                        end
                    end
                    if (bus.BTN[1]) begin
                        r_state <= S_CLEAR;
                        r_clr   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_clr <= r_clr + 1'b1;
                    if (r_clr == T_LAST) begin
                        r_pc    <= '0;
                        r_ptr   <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= (r_pc == r_prog_len) ? S_HALT : S_DECODE;
                end
                S_DECODE: begin
                    r_pc    <= r_pc + 1'b1;
                    r_state <= S_FETCH;
                    case (r_prog_q)
                        OP_RIGHT: r_ptr <= r_ptr + 1'b1;
                        OP_LEFT:  r_ptr <= r_ptr - 1'b1;
                        OP_OUT: begin
                            r_pc    <= r_pc;
                            r_state <= S_OUT;
                        end
                        OP_IN: begin
                            r_pc    <= r_pc;
                            r_state <= S_IN;
                        end
                        OP_OPEN: begin
                            if (r_tape_q == 8'd0) begin
                                r_depth <= 1;
                                r_state <= S_FRD;
                            end
                        end
                        OP_CLOSE: begin
                            if (r_tape_q != 8'd0) begin
                                r_depth <= 1;
                                if (r_pc == '0) begin
                                    r_pc     <= r_pc;
                                    r_err[1] <= 1'b1;
                                    r_state  <= S_HALT;
                                end else begin
                                    r_pc    <= r_pc - 1'b1;
                                    r_state <= S_BRD;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                S_OUT: begin
                    if (!r_tx_busy) begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_IN: begin
                    if (r_rx_valid) begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FRD: begin
                    if (r_pc == r_prog_len) begin
                        r_err[1] <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_state <= S_FCHK;
                    end
                end
                S_FCHK: begin
                    r_pc    <= r_pc + 1'b1;
                    r_state <= S_FRD;
                    if (r_prog_q == OP_OPEN) begin
                        r_depth <= r_depth + 1'b1;
                    end else if (r_prog_q == OP_CLOSE) begin
                        if (r_depth == 1) r_state <= S_FETCH;
                        else              r_depth <= r_depth - 1'b1;
                    end
                end
                S_BRD: begin
                    r_state <= S_BCHK;
                end
                S_BCHK: begin
                    if (r_prog_q == OP_OPEN && r_depth == 1) begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= S_FETCH;
                    end else begin
                        if (r_prog_q == OP_OPEN)
                            r_depth <= r_depth - 1'b1;
                        else if (r_prog_q == OP_CLOSE)
                            r_depth <= r_depth + 1'b1;
                        if (r_pc == '0) begin
                            r_err[1] <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_pc    <= r_pc - 1'b1;
                            r_state <= S_BRD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered LED view of state and sticky error flags
    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_led0 <= 3'b001;
            r_led1 <= 3'b000;
        end else begin
            r_led0 <= {r_state == S_HALT,
                       r_state != S_LOAD && r_state != S_HALT,
                       r_state == S_LOAD};
            r_led1 <= r_err;
        end
    end

    assign bus.UART_OUT = r_tx_out;
    assign bus.LED0     = r_led0;
    assign bus.LED1     = r_led1;
endmodule

// File: tb/tb_bf_uart_machine.sv
// Self-checking bench for bf_uart_machine: programs loaded over UART,
// TX bytes checked against a scoreboard queue, LEDs checked per scenario.
module tb_bf_uart_machine;
    localparam int CPB  = 16;
    localparam int TAPE = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    bf_uart_machine_if u_if ();

    bf_uart_machine #(
        .CLKS_PER_BIT(CPB),
        .PROG_DEPTH  (1024),
        .TAPE_DEPTH  (TAPE)
    ) dut (
        .CLK(clk),
        .bus(u_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sb[$];
    logic [7:0] pq[$];

    // Decode every TX frame and compare against the scoreboard
    always begin
        logic [7:0] got;
        logic [7:0] exp;
        logic       st;
        logic       sp;
        @(negedge u_if.UART_OUT);
        repeat (CPB / 2) @(posedge clk);
        #1 st = u_if.UART_OUT;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 got[i] = u_if.UART_OUT;
        end
        repeat (CPB) @(posedge clk);
        #1 sp = u_if.UART_OUT;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL tx_unexpected: got %h, expected no frame", got);
        end else begin
            exp = sb.pop_front();
            if ({sp, got, st} !== {1'b1, exp, 1'b0})
                $display("FAIL tx_byte: got %h st=%b sp=%b, expected %h",
                         got, st, sp, exp);
            else
                n_pass++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        u_if.BTN = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        #2 u_if.BTN = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        u_if.UART_IN = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.UART_IN = d[i];
            repeat (CPB) @(negedge clk);
        end
        u_if.UART_IN = stop;
        repeat (CPB) @(negedge clk);
        u_if.UART_IN = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic press_run();
        @(negedge clk);
        u_if.BTN[1] = 1'b1;
        @(negedge clk);
        u_if.BTN[1] = 1'b0;
    endtask

    task automatic load_and_run();
        do_reset();
        foreach (pq[i]) send_frame(pq[i], 1'b1);
        press_run();
    endtask

    task automatic wait_halt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if (u_if.LED0 === 3'b100) ok = 1'b1;
        end
        repeat (12 * CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (u_if.LED0 !== 3'b001)
            $display("FAIL reset_led0: got %b, expected 001", u_if.LED0);
        else n_pass++;
        n_checks++;
        if (u_if.LED1 !== 3'b000)
            $display("FAIL reset_led1: got %b, expected 000", u_if.LED1);
        else n_pass++;
        n_checks++;
        if (u_if.UART_OUT !== 1'b1)
            $display("FAIL reset_tx: got %b, expected 1", u_if.UART_OUT);
        else n_pass++;
    endtask

    task automatic check_end(input string nm, input logic [2:0] led1);
        bit ok;
        wait_halt(ok);
        n_checks++;
        if (!ok)
            $display("FAIL %s_halt: LED0=%b, expected 100", nm, u_if.LED0);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL %s_drain: %0d bytes missing, expected 0",
                     nm, sb.size());
        else n_pass++;
        n_checks++;
        if (u_if.LED1 !== led1)
            $display("FAIL %s_led1: got %b, expected %b", nm, u_if.LED1, led1);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_noop();
        pq = '{8'h53, 8'h0F};
        sb = {};
        load_and_run();
        repeat (3) @(negedge clk);
        n_checks++;
        if (u_if.LED0 !== 3'b010)
            $display("FAIL noop_run: LED0=%b, expected 010", u_if.LED0);
        else n_pass++;
        check_end("noop", 3'b000);
    endtask

    task automatic test_increment();
        pq = '{8'h2B, 8'h2B, 8'h2B, 8'h2E};
        sb = '{8'h03};
        load_and_run();
        check_end("inc", 3'b000);
    endtask

    task automatic test_decrement();
        pq = '{8'h2D, 8'h2E};
        sb = '{8'hFF};
        load_and_run();
        check_end("dec", 3'b000);
    endtask

    task automatic test_wrap();
        pq = '{8'h3C, 8'h2B, 8'h2E};
        sb = '{8'h01};
        load_and_run();
        check_end("wrap_a", 3'b000);
        pq = '{8'h2B, 8'h3C, 8'h2E, 8'h3E, 8'h2E};
        sb = '{8'h00, 8'h01};
        load_and_run();
        check_end("wrap_b", 3'b000);
    endtask

    task automatic test_loop();
        pq = '{8'h2B, 8'h2B, 8'h5B, 8'h3E, 8'h2B, 8'h2B, 8'h2B,
               8'h3C, 8'h2D, 8'h5D, 8'h3E, 8'h2E};
        sb = '{8'h06};
        load_and_run();
        check_end("loop", 3'b000);
        pq = '{8'h5B, 8'h2B, 8'h5B, 8'h5D, 8'h5D, 8'h2B, 8'h2E};
        sb = '{8'h01};
        load_and_run();
        check_end("skip", 3'b000);
    endtask

    task automatic test_back_to_back();
        pq = '{8'h2B, 8'h2E, 8'h2B, 8'h2E, 8'h2D, 8'h2D, 8'h2D, 8'h2E};
        sb = '{8'h01, 8'h02, 8'hFF};
        load_and_run();
        check_end("b2b", 3'b000);
    endtask

    task automatic test_unmatched();
        pq = '{8'h5B};
        sb = {};
        load_and_run();
        check_end("unm_fwd", 3'b010);
        pq = '{8'h2B, 8'h5D};
        sb = {};
        load_and_run();
        check_end("unm_bwd", 3'b010);
    endtask

    task automatic test_input();
        pq = '{8'h2C, 8'h2B, 8'h2E};
        sb = '{8'h42};
        load_and_run();
        repeat (TAPE + 20) @(negedge clk);
        n_checks++;
        if (u_if.LED0 !== 3'b010)
            $display("FAIL in_wait: LED0=%b, expected 010", u_if.LED0);
        else n_pass++;
        send_frame(8'h41, 1'b1);
        check_end("input", 3'b000);
    endtask

    task automatic test_frame_error();
        do_reset();
        send_frame(8'h2E, 1'b0);
        send_frame(8'h2B, 1'b1);
        send_frame(8'h2E, 1'b1);
        sb = '{8'h01};
        press_run();
        check_end("ferr", 3'b001);
    endtask

    initial begin
        u_if.BTN     = 4'b0001;
        u_if.UART_IN = 1'b1;
        test_reset();
        test_noop();
        test_increment();
        test_decrement();
        test_wrap();
        test_loop();
        test_back_to_back();
        test_unmatched();
        test_input();
        test_frame_error();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
